// File: rtl/vram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// vram_bus_arbiter
//
// Bus-grant responder for the CRTC row-fetch DMA. A CRTC bus request is
// turned into a Z80 BUSRQ. Once the CPU answers with BUSAK, the CRTC is
// acknowledged and the RAM address port is steered to the DMA address.
// Outside a grant, CPU memory cycles pass straight through to RAM.
//
// Parameters:
//   REL_HOLD  cycles BUSRQ stays asserted after the DMA request drops (>= 1)
//   TIMEOUT   cycles to wait for BUSAK before abandoning a request (>= 1,
//             fits the 12-bit wait counter)
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   dma_req        CRTC busreq
//   dma_adr        CRTC ram_adr (17 bits)
//   dma_ack        CRTC busack (registered)
//   dma_data       CRTC ram_data, straight from mem_dout
//   cpu_busrq_n    Z80 BUSRQ, active-low (registered)
//   cpu_busak_n    Z80 BUSAK, active-low
//   cpu_adr        CPU address including bank bit 16
//   cpu_mreq_n     CPU memory request strobe, active-low
//   cpu_wr_n       CPU write strobe, active-low
//   cpu_dout       CPU write data
//   cpu_din        RAM read data to CPU, straight from mem_dout
//   mem_adr        RAM address
//   mem_din        RAM write data
//   mem_we         RAM write enable, never asserted during a grant
//   mem_dout       RAM read data (one-cycle synchronous latency)
//   timeout_flag   sticky: a request was abandoned for lack of BUSAK
//   proto_err      sticky: BUSAK was released during a grant
//   grant_cnt      completed grants, wraps 255 -> 0
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | bus belongs to the CPU, BUSRQ released
// REQ   | BUSRQ asserted, waiting for BUSAK (bounded by TIMEOUT)
// GRANT | CPU off the bus, RAM address steered to the DMA
// HOLD  | DMA done, BUSRQ kept asserted REL_HOLD cycles before release
// ---------------------------------------------------------------------------
module vram_bus_arbiter #(
   parameter int REL_HOLD = 2,
   parameter int TIMEOUT  = 4095
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dma_req,
   input  logic [16:0] dma_adr,
   output logic        dma_ack,
   output logic [7:0]  dma_data,
   output logic        cpu_busrq_n,
   input  logic        cpu_busak_n,
   input  logic [16:0] cpu_adr,
   input  logic        cpu_mreq_n,
   input  logic        cpu_wr_n,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   output logic [16:0] mem_adr,
   output logic [7:0]  mem_din,
   output logic        mem_we,
   input  logic [7:0]  mem_dout,
   output logic        timeout_flag,
   output logic        proto_err,
   output logic [7:0]  grant_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_GRANT = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   // Terminal counts: the counter starts at 0 on state entry, so the exit
   // edge is the one at which it already holds N-1.
   localparam logic [11:0] TIMEOUT_TC = 12'(TIMEOUT - 1);
   localparam logic [11:0] HOLD_TC    = 12'(REL_HOLD - 1);

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [11:0] tmr_cnt;
   logic [11:0] tmr_nxt;
   logic        timeout_set;
   logic        proto_set;
   logic        grant_done;

   // -----------------------------------------------------------------------
   // Next-state logic. The one counter serves as the BUSAK wait timer in
   // REQ and as the release timer in HOLD; it is zero on entry to both.
   // -----------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      tmr_nxt     = tmr_cnt;
      timeout_set = 1'b0;
      proto_set   = 1'b0;
      grant_done  = 1'b0;
      case (state)
         ST_IDLE: begin
            tmr_nxt = 12'd0;
            if (dma_req) begin
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            // Priority: request withdrawn, then BUSAK (grant beats a
            // coincident timeout), then the timeout itself.
            if (!dma_req) begin
               state_nxt = ST_IDLE;
               tmr_nxt   = 12'd0;
            end else if (!cpu_busak_n) begin
               state_nxt = ST_GRANT;
               tmr_nxt   = 12'd0;
            end else if (tmr_cnt == TIMEOUT_TC) begin
               state_nxt   = ST_IDLE;
               tmr_nxt     = 12'd0;
               timeout_set = 1'b1;
            end else begin
               tmr_nxt = tmr_cnt + 12'd1;
            end
         end
         ST_GRANT: begin
            // Losing BUSAK is checked first so a coincident request drop
            // is reported as a protocol error and not counted.
            if (cpu_busak_n) begin
               state_nxt = ST_IDLE;
               proto_set = 1'b1;
            end else if (!dma_req) begin
               state_nxt  = ST_HOLD;
               tmr_nxt    = 12'd0;
               grant_done = 1'b1;
            end
         end
         ST_HOLD: begin
            if (tmr_cnt == HOLD_TC) begin
               state_nxt = ST_IDLE;
               tmr_nxt   = 12'd0;
            end else begin
               tmr_nxt = tmr_cnt + 12'd1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            tmr_nxt   = 12'd0;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // State, handshake outputs and status. dma_ack and cpu_busrq_n are
   // decoded from the next state so they are clean flops aligned with it.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         tmr_cnt      <= 12'd0;
         dma_ack      <= 1'b0;
         cpu_busrq_n  <= 1'b1;
         timeout_flag <= 1'b0;
         proto_err    <= 1'b0;
         grant_cnt    <= 8'd0;
      end else begin
         state       <= state_nxt;
         tmr_cnt     <= tmr_nxt;
         dma_ack     <= (state_nxt == ST_GRANT);
         cpu_busrq_n <= (state_nxt == ST_IDLE);
         if (timeout_set) begin
            timeout_flag <= 1'b1;
         end
         if (proto_set) begin
            proto_err <= 1'b1;
         end
         if (grant_done) begin
            grant_cnt <= grant_cnt + 8'd1;
         end
      end
   end

   // -----------------------------------------------------------------------
   // RAM port steering. Follows the registered state: during GRANT the DMA
   // owns the address and CPU write strobes are dropped.
   // -----------------------------------------------------------------------
   logic in_grant;
   assign in_grant = (state == ST_GRANT);

   always_comb begin
      mem_adr = cpu_adr;
      mem_we  = ~cpu_mreq_n & ~cpu_wr_n;
      if (in_grant) begin
         mem_adr = dma_adr;
         mem_we  = 1'b0;
      end
   end

   assign mem_din  = cpu_dout;

   // Both consumers see every read; each qualifies by its own bus phase.
   assign dma_data = mem_dout;
   assign cpu_din  = mem_dout;

endmodule
